// File: rtl/ram_sync_clr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync_clr_pkg
// Purpose  : Shared types and default constants for the soft-clearable
//            synchronous RAM (ram_sync_clr) and its clear sequencer
//            (ram_clear_seq).
// Contents : state_t     - clear-sequencer state (CLEAR, IDLE)
//            DATA_W_DEF  - default word width
//            ADDR_W_DEF  - default address width
// Revision : 1.0 - initial release
// ============================================================================
package ram_sync_clr_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage : ram_sync_clr_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_clear_seq
// Purpose  : Clear-sweep sequencer. Walks every address once, one word per
//            cycle, issuing a zero-write strobe, then parks in IDLE until a
//            new clear request arrives. Reset starts a sweep.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            start    - begin a sweep (only honoured in IDLE)
//            busy     - 1 while the sweep runs
//            clr_addr - address being zeroed this cycle
//            clr_we   - zero-write strobe for clr_addr
// Revision : 1.0 - initial release
// ============================================================================
module ram_clear_seq
    import ram_sync_clr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                // Last word zeroed this cycle: leave with the counter rewound
                // so the next sweep starts at address 0.
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_sync_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync_clr
// Purpose  : Single-port synchronous RAM with registered read data and a
//            soft-clear sweep that zeroes every word, one per cycle. The
//            array itself has no reset; reset launches a sweep instead.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            cs         - chip select, qualifies a request
//            write_en   - 1 = write, 0 = read
//            addr       - word address
//            data_in    - write data
//            clr        - single-cycle soft-clear request
//            data_out   - registered read data (holds when no read)
//            rd_valid   - one-cycle pulse, the cycle after an accepted read
//            busy       - 1 while a clear sweep runs
//            parity_err - (RAM_SYNC_CLR_PARITY_EN only) stored even parity
//                         disagrees with the word read; pulses with rd_valid
// Config   : `define RAM_SYNC_CLR_PARITY_EN adds per-word parity storage and
//            the parity_err output.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sync_clr
    import ram_sync_clr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
`ifdef RAM_SYNC_CLR_PARITY_EN
   ,output logic              parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              req_ok;
    logic              wr_acc;
    logic              rd_acc;
    logic              start;

    // A request only counts in IDLE, and a same-cycle clear takes priority.
    assign req_ok = cs && !clr && !busy;
    assign wr_acc = req_ok && write_en;
    assign rd_acc = req_ok && !write_en;
    assign start  = clr && !busy;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[addr];
            end
        end
    end

`ifdef RAM_SYNC_CLR_PARITY_EN
    logic par_mem [DEPTH];

    // Zero words carry even parity 0, so the sweep writes a consistent bit.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= 1'b0;
        end else if (wr_acc) begin
            par_mem[addr] <= ^data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_acc && (par_mem[addr] != (^mem[addr]));
        end
    end
`endif

endmodule : ram_sync_clr
`default_nettype wire

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 4, word width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cs, input, 1, chip select; qualifies a request.
REQ-006 SHALL have port write_en, input, 1, 1 = write, 0 = read (valid only with cs).
REQ-007 SHALL have port addr, input, ADDR_W, word address.
REQ-008 SHALL have port data_in, input, DATA_W, write data.
REQ-009 SHALL have port clr, input, 1, single-cycle soft-clear request.
REQ-010 SHALL have port data_out, output, DATA_W, registered read data.
REQ-011 SHALL have port rd_valid, output, 1, high exactly one cycle per accepted read.
REQ-012 SHALL have port busy, output, 1, high while a clear sweep runs.

Function
REQ-013 SHALL implement FSM states CLEAR and IDLE only.
REQ-014 In CLEAR: one word per cycle, mem[cnt] <= 0, cnt from 0 to DEPTH-1; after writing DEPTH-1 -> IDLE, cnt <= 0; sweep takes exactly DEPTH cycles.
REQ-015 busy SHALL be 1 in CLEAR, 0 in IDLE (registered state decode).
REQ-016 In CLEAR, cs/write_en/clr SHALL be ignored: no write, rd_valid stays 0, cnt not restarted.
REQ-017 In IDLE, clr=1 -> CLEAR next cycle; any cs request that same cycle SHALL be dropped (clr wins).
REQ-018 In IDLE, cs=1, write_en=1, clr=0: mem[addr] <= data_in at that edge; rd_valid stays 0.
REQ-019 In IDLE, cs=1, write_en=0, clr=0: data_out <= mem[addr] at that edge; rd_valid=1 for the following cycle (latency 1).
REQ-020 data_out SHALL hold its last value when no read is accepted, including through CLEAR.
REQ-021 Read of an address written the previous cycle SHALL return the new data; back-to-back reads SHALL give rd_valid every cycle.
REQ-022 cs=0 SHALL cause no memory or output change except FSM/clear progress.

Reset
REQ-023 rst_n=0 SHALL immediately force state=CLEAR, cnt=0, data_out=0, rd_valid=0, busy=1.
REQ-024 On rst_n release, a full DEPTH-cycle sweep SHALL run; reset mid-sweep or mid-read SHALL restart from cnt=0 and drop the pending rd_valid.
REQ-025 Memory array SHALL not be reset directly; zeroing is done only by the sweep.

Configuration
REQ-026 Macro RAM_SYNC_CLR_PARITY_EN SHALL, when defined, store one even-parity bit per word (written with data; 0 by sweep), add output parity_err (1 bit), pulsed with rd_valid when stored parity mismatches recomputed parity of read data; parity_err reset value 0.
REQ-027 Without RAM_SYNC_CLR_PARITY_EN, port parity_err and parity storage SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package ram_sync_clr_pkg SHALL hold typedef enum state_t {CLEAR, IDLE} and default constants DATA_W_DEF=4, ADDR_W_DEF=4.
REQ-029 Sweep FSM and counter SHALL be sub-module ram_clear_seq (outputs busy, clear address, clear write strobe); array, read register and parity in ram_sync_clr.

Verification
REQ-030 Reset release, defaults: busy=1 for exactly 16 cycles then 0; reads of addr 0..15 all return 0 with rd_valid one cycle after each cs.
REQ-031 Write 4'hA to addr 3, next cycle read addr 3 -> data_out=4'hA, rd_valid=1 one cycle later; addr 4 read -> 4'h0.
REQ-032 clr with cs read same cycle in IDLE -> no rd_valid, busy=1 next cycle for 16 cycles; prior 4'hA at addr 3 reads 0 afterwards.
REQ-033 Write 4'h5 to addr 7 during busy -> ignored; after sweep addr 7 reads 0.
REQ-034 rst_n asserted at sweep cycle 8 and mid-read -> data_out=0, rd_valid=0 immediately; after release, full 16-cycle sweep again.
REQ-035 DATA_W=8, ADDR_W=6 with RAM_SYNC_CLR_PARITY_EN: busy 64 cycles; write 8'h7F to addr 63, read -> 8'h7F, parity_err=0; all sweep-cleared reads parity_err=0.
